// File: rtl/vertex_list_writer.sv
// Vertex RAM writer: packs {x,y,z} float words into 96-bit records, writes whole
// triangles from address 0 and closes each list with an x=FFFFFFFF terminator.
// Optional feature: define VTX_SANITIZE_EN to rewrite incoming x=FFFFFFFF as canonical NaN.
module vertex_list_writer #(
  parameter int unsigned DEPTH  = 4096,
  parameter int unsigned ADDR_W = 12
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              begin_list,
  input  logic              s_valid,
  output logic              s_ready,
  input  logic [31:0]       s_data,
  input  logic              s_last,
  output logic              wr_en,
  output logic [ADDR_W-1:0] wr_addr,
  output logic [95:0]       wr_data,
  output logic              busy,
  output logic              done,
  output logic [ADDR_W-1:0] vertex_count,
  output logic              err_partial,
  output logic              err_overflow,
  output logic              sanitize_hit
);

  localparam int unsigned WORD_W    = 32;
  localparam int unsigned REC_W     = 3 * WORD_W;
  localparam int unsigned LAST_SLOT = DEPTH - 1;
  localparam logic [WORD_W-1:0] TERM_X    = 32'hFFFF_FFFF;
  localparam logic [WORD_W-1:0] CANON_NAN = 32'h7FC0_0000;
  localparam logic [REC_W-1:0]  TERM_REC  = {TERM_X, 64'h0};

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    COLLECT   = 3'd1,
    DROP      = 3'd2,
    TERMINATE = 3'd3,
    DONE      = 3'd4
  } state_t;

  state_t state, state_d;

  logic [ADDR_W-1:0] wr_ptr, wr_ptr_d;
  logic [ADDR_W-1:0] tri_base, tri_base_d;
  logic [1:0]        word_idx, word_idx_d;
  logic [1:0]        vert_idx, vert_idx_d;
  logic [WORD_W-1:0] x_q, x_d, y_q, y_d;

  logic              wr_en_d, busy_d, done_d, s_ready_d;
  logic [ADDR_W-1:0] wr_addr_d, vertex_count_d;
  logic [REC_W-1:0]  wr_data_d;
  logic              err_partial_d, err_overflow_d, sanitize_hit_d;

  logic              hs;
  logic              tri_start;
  logic              cap_fail;
  logic              ovf_hit;
  logic              tri_done;
  logic              x_is_term;
  logic [WORD_W-1:0] x_word;

  // Handshake decode shared by next-state and output logic
  assign hs        = s_valid & s_ready;
  assign tri_start = (word_idx == 2'd0) && (vert_idx == 2'd0);
  assign cap_fail  = (32'(tri_base) + 32'd3) > LAST_SLOT;
  assign ovf_hit   = tri_start && cap_fail;
  assign tri_done  = (word_idx == 2'd2) && (vert_idx == 2'd2);

`ifdef VTX_SANITIZE_EN
  assign x_is_term = (s_data == TERM_X);
  assign x_word    = x_is_term ? CANON_NAN : s_data;
`else
  assign x_is_term = 1'b0;
  assign x_word    = s_data;
`endif

  // State register
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state <= IDLE;
    else          state <= state_d;
  end

  // Next-state logic
  always_comb begin
    state_d = state;
    unique case (state)
      IDLE:      if (begin_list) state_d = COLLECT;
      COLLECT: begin
        if (hs) begin
          if (ovf_hit)     state_d = s_last ? DONE : DROP;
          else if (s_last) state_d = tri_done ? TERMINATE : DONE;
        end
      end
      DROP:      if (hs && s_last) state_d = DONE;
      TERMINATE: state_d = DONE;
      DONE:      state_d = IDLE;
      default:   state_d = IDLE;
    endcase
  end

  // Output / datapath next values; lists that end off a triangle boundary
  // write the terminator straight away instead of passing through TERMINATE.
  always_comb begin
    wr_en_d        = 1'b0;
    wr_addr_d      = wr_addr;
    wr_data_d      = wr_data;
    busy_d         = (state != IDLE) || begin_list;
    done_d         = 1'b0;
    vertex_count_d = vertex_count;
    err_partial_d  = err_partial;
    err_overflow_d = err_overflow;
    sanitize_hit_d = sanitize_hit;
    s_ready_d      = (state_d == COLLECT) || (state_d == DROP);
    wr_ptr_d       = wr_ptr;
    tri_base_d     = tri_base;
    word_idx_d     = word_idx;
    vert_idx_d     = vert_idx;
    x_d            = x_q;
    y_d            = y_q;

    unique case (state)
      IDLE: begin
        if (begin_list) begin
          wr_ptr_d       = '0;
          tri_base_d     = '0;
          word_idx_d     = 2'd0;
          vert_idx_d     = 2'd0;
          err_partial_d  = 1'b0;
          err_overflow_d = 1'b0;
          sanitize_hit_d = 1'b0;
        end
      end
      COLLECT: begin
        if (hs) begin
          if (ovf_hit) begin
            err_overflow_d = 1'b1;
            if (s_last) begin
              wr_en_d   = 1'b1;
              wr_addr_d = tri_base;
              wr_data_d = TERM_REC;
            end
          end else begin
            unique case (word_idx)
              2'd0: begin
                x_d        = x_word;
                word_idx_d = 2'd1;
                if (x_is_term) sanitize_hit_d = 1'b1;
              end
              2'd1: begin
                y_d        = s_data;
                word_idx_d = 2'd2;
              end
              default: begin
                wr_en_d    = 1'b1;
                wr_addr_d  = wr_ptr;
                wr_data_d  = {x_q, y_q, s_data};
                wr_ptr_d   = wr_ptr + ADDR_W'(1);
                word_idx_d = 2'd0;
                if (vert_idx == 2'd2) begin
                  vert_idx_d = 2'd0;
                  tri_base_d = wr_ptr + ADDR_W'(1);
                end else begin
                  vert_idx_d = vert_idx + 2'd1;
                end
              end
            endcase
            // Partial triangle: nothing more is written except the terminator
            if (s_last && !tri_done) begin
              err_partial_d = 1'b1;
              wr_en_d       = 1'b1;
              wr_addr_d     = tri_base;
              wr_data_d     = TERM_REC;
            end
          end
        end
      end
      DROP: begin
        if (hs && s_last) begin
          wr_en_d   = 1'b1;
          wr_addr_d = tri_base;
          wr_data_d = TERM_REC;
        end
      end
      TERMINATE: begin
        wr_en_d   = 1'b1;
        wr_addr_d = tri_base;
        wr_data_d = TERM_REC;
      end
      DONE: begin
        done_d         = 1'b1;
        vertex_count_d = tri_base;
      end
      default: ;
    endcase
  end

  // Registered outputs and datapath
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_en        <= 1'b0;
      wr_addr      <= '0;
      wr_data      <= '0;
      busy         <= 1'b0;
      done         <= 1'b0;
      vertex_count <= '0;
      err_partial  <= 1'b0;
      err_overflow <= 1'b0;
      sanitize_hit <= 1'b0;
      s_ready      <= 1'b0;
      wr_ptr       <= '0;
      tri_base     <= '0;
      word_idx     <= 2'd0;
      vert_idx     <= 2'd0;
      x_q          <= '0;
      y_q          <= '0;
    end else begin
      wr_en        <= wr_en_d;
      wr_addr      <= wr_addr_d;
      wr_data      <= wr_data_d;
      busy         <= busy_d;
      done         <= done_d;
      vertex_count <= vertex_count_d;
      err_partial  <= err_partial_d;
      err_overflow <= err_overflow_d;
      sanitize_hit <= sanitize_hit_d;
      s_ready      <= s_ready_d;
      wr_ptr       <= wr_ptr_d;
      tri_base     <= tri_base_d;
      word_idx     <= word_idx_d;
      vert_idx     <= vert_idx_d;
      x_q          <= x_d;
      y_q          <= y_d;
    end
  end

endmodule
